// File: rtl/mem_bus_arbiter_pkg.sv
// Typed view of the shared C2 bus constants plus the arbiter state encoding.
`include "consts.sv"

package mem_bus_arbiter_pkg;

   localparam int CTR2_W  = `CTR2_BUS_SIZE;
   localparam int ADDR2_W = `ADDR2_BUS_SIZE;
   localparam int DATA2_W = `DATA2_BUS_SIZE;
   localparam int LINE_W  = `MEM_LINE_SIZE;

   localparam logic [CTR2_W-1:0] C2_NOP        = `C2_NOP;
   localparam logic [CTR2_W-1:0] C2_READ_LINE  = `C2_READ_LINE;
   localparam logic [CTR2_W-1:0] C2_WRITE_LINE = `C2_WRITE_LINE;
   localparam logic [CTR2_W-1:0] C2_RESPONSE   = `C2_RESPONSE;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CMD      = 3'd1,
      ST_WDATA    = 3'd2,
      ST_WAIT_RSP = 3'd3,
      ST_RDATA    = 3'd4,
      ST_TURN     = 3'd5
   } arb_state_e;

   // Only whole-line reads and writes may be issued by a requester.
   function automatic logic is_line_cmd(input logic [CTR2_W-1:0] cmd);
      return (cmd == C2_READ_LINE) || (cmd == C2_WRITE_LINE);
   endfunction

endpackage

// File: rtl/consts.sv
// Shared C2 memory-bus constants: command codes and bus widths.
`ifndef MEM_BUS_CONSTS_SV
`define MEM_BUS_CONSTS_SV

`define CTR2_BUS_SIZE  2
`define ADDR2_BUS_SIZE 32
`define DATA2_BUS_SIZE 16
`define MEM_LINE_SIZE  128

`define C2_NOP        2'b00
`define C2_READ_LINE  2'b01
`define C2_WRITE_LINE 2'b10
`define C2_RESPONSE   2'b11

`endif

// File: rtl/mem_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr wins.
module rr_arbiter #(
   parameter int N_REQ = 2,
   parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [PW-1:0]    gnt_idx,
   output logic             any
);

   function automatic int wrap_idx(input int p, input int i);
      return (p + i) % N_REQ;
   endfunction

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!any && req[wrap_idx(int'(ptr), i)]) begin
            gnt[wrap_idx(int'(ptr), i)] = 1'b1;
            gnt_idx = PW'(wrap_idx(int'(ptr), i));
            any     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter granting N_REQ caches exclusive use of the C2 line bus.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int N_REQ   = 2,
   parameter int BEATS   = LINE_W / DATA2_W,
   parameter int TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*CTR2_W-1:0]   req_cmd,
   input  logic [N_REQ*ADDR2_W-1:0]  req_addr,
   input  logic [N_REQ*DATA2_W-1:0]  req_wdata,
   output logic [N_REQ-1:0]          req_ready,
   output logic [N_REQ-1:0]          wdata_ready,
   output logic [N_REQ-1:0]          rsp_valid,
   output logic [DATA2_W-1:0]        rsp_data,
   output logic                      rsp_last,
   output logic                      rsp_err,
   output logic [N_REQ-1:0]          grant,
   output logic [ADDR2_W-1:0]        a2_out,
   output logic [CTR2_W-1:0]         c2_out,
   output logic                      c2_oe,
   output logic [DATA2_W-1:0]        d2_out,
   output logic                      d2_oe,
   input  logic [CTR2_W-1:0]         c2_in,
   input  logic [DATA2_W-1:0]        d2_in,
   output arb_state_e                dbg_state
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   arb_state_e         state_q, state_d;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic [N_REQ-1:0]   owner_q, owner_d;
   logic [PW-1:0]      owner_idx_q, owner_idx_d;
   logic [CTR2_W-1:0]  cmd_q, cmd_d;
   logic [ADDR2_W-1:0] addr_q, addr_d;
   logic [BW-1:0]      beat_q, beat_d;
   logic [TW-1:0]      wait_q, wait_d;

   logic [N_REQ-1:0]   arb_req;
   logic [N_REQ-1:0]   win_gnt;
   logic [PW-1:0]      win_idx;
   logic               win_any;
   logic [CTR2_W-1:0]  win_cmd;
   logic [ADDR2_W-1:0] win_addr;
   logic [DATA2_W-1:0] owner_wdata;
   logic               last_beat;

   // Requests are masked while reset is held so every output reads zero.
   assign arb_req = reset ? '0 : req_valid;

   rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_rr (
      .req     (arb_req),
      .ptr     (ptr_q),
      .gnt     (win_gnt),
      .gnt_idx (win_idx),
      .any     (win_any)
   );

   assign win_cmd     = req_cmd[int'(win_idx)*CTR2_W +: CTR2_W];
   assign win_addr    = req_addr[int'(win_idx)*ADDR2_W +: ADDR2_W];
   assign owner_wdata = req_wdata[int'(owner_idx_q)*DATA2_W +: DATA2_W];
   assign last_beat   = (beat_q == BW'(BEATS - 1));
   assign dbg_state   = state_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         owner_idx_q <= '0;
         cmd_q       <= C2_NOP;
         addr_q      <= '0;
         beat_q      <= '0;
         wait_q      <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         owner_idx_q <= owner_idx_d;
         cmd_q       <= cmd_d;
         addr_q      <= addr_d;
         beat_q      <= beat_d;
         wait_q      <= wait_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      owner_idx_d = owner_idx_q;
      cmd_d       = cmd_q;
      addr_d      = addr_q;
      beat_d      = beat_q;
      wait_d      = wait_q;
      req_ready   = '0;
      wdata_ready = '0;
      rsp_valid   = '0;
      rsp_data    = '0;
      rsp_last    = 1'b0;
      rsp_err     = 1'b0;
      grant       = '0;
      a2_out      = '0;
      c2_out      = C2_NOP;
      c2_oe       = 1'b0;
      d2_out      = '0;
      d2_oe       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (win_any) begin
               req_ready = win_gnt;
               ptr_d     = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
               if (is_line_cmd(win_cmd)) begin
                  grant       = win_gnt;
                  owner_d     = win_gnt;
                  owner_idx_d = win_idx;
                  cmd_d       = win_cmd;
                  addr_d      = win_addr;
                  state_d     = ST_CMD;
               end else begin
                  // Rejected in place: the bus is never touched.
                  rsp_valid = win_gnt;
                  rsp_last  = 1'b1;
                  rsp_err   = 1'b1;
               end
            end
         end

         ST_CMD: begin
            grant   = owner_q;
            c2_oe   = 1'b1;
            c2_out  = cmd_q;
            a2_out  = addr_q;
            beat_d  = '0;
            wait_d  = '0;
            state_d = (cmd_q == C2_WRITE_LINE) ? ST_WDATA : ST_WAIT_RSP;
         end

         ST_WDATA: begin
            grant       = owner_q;
            c2_oe       = 1'b1;
            c2_out      = C2_WRITE_LINE;
            a2_out      = addr_q;
            d2_oe       = 1'b1;
            d2_out      = owner_wdata;
            wdata_ready = owner_q;
            if (last_beat) begin
               beat_d  = '0;
               state_d = ST_WAIT_RSP;
            end else begin
               beat_d = beat_q + BW'(1);
            end
         end

         ST_WAIT_RSP: begin
            grant = owner_q;
            if (c2_in == C2_RESPONSE) begin
               rsp_valid = owner_q;
               if (cmd_q == C2_READ_LINE) begin
                  // Beat 0 arrives together with the response code.
                  rsp_data = d2_in;
                  rsp_last = last_beat;
                  beat_d   = last_beat ? '0 : beat_q + BW'(1);
                  state_d  = last_beat ? ST_TURN : ST_RDATA;
               end else begin
                  rsp_last = 1'b1;
                  state_d  = ST_TURN;
               end
            end else if (wait_q == TW'(TIMEOUT)) begin
               rsp_valid = owner_q;
               rsp_last  = 1'b1;
               rsp_err   = 1'b1;
               state_d   = ST_TURN;
            end else begin
               wait_d = wait_q + TW'(1);
            end
         end

         ST_RDATA: begin
            grant     = owner_q;
            rsp_valid = owner_q;
            rsp_data  = d2_in;
            rsp_last  = last_beat;
            if (last_beat) begin
               beat_d  = '0;
               state_d = ST_TURN;
            end else begin
               beat_d = beat_q + BW'(1);
            end
         end

         ST_TURN: begin
            owner_d = '0;
            wait_d  = '0;
            beat_d  = '0;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a hand-driven C2 memory side.
module tb_mem_bus_arbiter;
   import mem_bus_arbiter_pkg::*;

   localparam int N_REQ   = 2;
   localparam int BEATS   = LINE_W / DATA2_W;
   localparam int TIMEOUT = 255;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [N_REQ-1:0]         req_valid;
   logic [N_REQ*CTR2_W-1:0]  req_cmd;
   logic [N_REQ*ADDR2_W-1:0] req_addr;
   logic [N_REQ*DATA2_W-1:0] req_wdata;
   logic [N_REQ-1:0]         req_ready;
   logic [N_REQ-1:0]         wdata_ready;
   logic [N_REQ-1:0]         rsp_valid;
   logic [DATA2_W-1:0]       rsp_data;
   logic                     rsp_last;
   logic                     rsp_err;
   logic [N_REQ-1:0]         grant;
   logic [ADDR2_W-1:0]       a2_out;
   logic [CTR2_W-1:0]        c2_out;
   logic                     c2_oe;
   logic [DATA2_W-1:0]       d2_out;
   logic                     d2_oe;
   logic [CTR2_W-1:0]        c2_in;
   logic [DATA2_W-1:0]       d2_in;
   arb_state_e               dbg_state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.N_REQ(N_REQ), .BEATS(BEATS), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_cmd     (req_cmd),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_ready   (req_ready),
      .wdata_ready (wdata_ready),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .rsp_last    (rsp_last),
      .rsp_err     (rsp_err),
      .grant       (grant),
      .a2_out      (a2_out),
      .c2_out      (c2_out),
      .c2_oe       (c2_oe),
      .d2_out      (d2_out),
      .d2_oe       (d2_oe),
      .c2_in       (c2_in),
      .d2_in       (d2_in),
      .dbg_state   (dbg_state)
   );

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      req_valid = '0;
      req_cmd   = '0;
      req_addr  = '0;
      req_wdata = '0;
      c2_in     = C2_NOP;
      d2_in     = '0;
   endtask

   task automatic set_req(input int idx, input logic [CTR2_W-1:0] cmd,
                          input logic [ADDR2_W-1:0] addr);
      req_valid[idx]                    = 1'b1;
      req_cmd[idx*CTR2_W +: CTR2_W]     = cmd;
      req_addr[idx*ADDR2_W +: ADDR2_W]  = addr;
   endtask

   // Called in the accept cycle; returns at the start of the next IDLE cycle.
   task automatic finish_read_quick();
      tick();
      req_valid = '0;
      tick();
      c2_in = C2_RESPONSE;
      d2_in = 16'h0200;
      for (int b = 1; b < BEATS; b++) begin
         tick();
         c2_in = C2_NOP;
         d2_in = 16'h0200 + DATA2_W'(b);
      end
      tick();
      d2_in = '0;
      tick();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      #2;
      checks++;
      if ({grant, req_ready, wdata_ready, rsp_valid, rsp_data, rsp_last, rsp_err,
           a2_out, c2_out, c2_oe, d2_out, d2_oe} !== '0 || dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_outputs: grant=%b c2_oe=%b d2_oe=%b rsp_valid=%b state=%0d, required all zero and IDLE",
                  grant, c2_oe, d2_oe, rsp_valid, dbg_state);
      end
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      tick();
   endtask

   task automatic test_read();
      logic bad;
      set_req(0, C2_READ_LINE, 32'h12);
      sample();
      checks++;
      if (grant !== 2'b01 || req_ready !== 2'b01) begin
         errors++;
         $display("FAIL read_accept: grant=%b req_ready=%b, required 01/01", grant, req_ready);
      end
      tick();
      req_valid = '0;
      sample();
      checks++;
      if (c2_oe !== 1'b1 || c2_out !== C2_READ_LINE || a2_out !== 32'h12 || d2_oe !== 1'b0) begin
         errors++;
         $display("FAIL read_cmd: c2_oe=%b c2_out=%0d a2_out=%h d2_oe=%b, required 1/%0d/12/0",
                  c2_oe, c2_out, a2_out, d2_oe, C2_READ_LINE);
      end
      bad = 1'b0;
      for (int k = 0; k < 196; k++) begin
         tick();
         sample();
         if (rsp_valid !== '0 || c2_oe !== 1'b0 || d2_oe !== 1'b0 || grant !== 2'b01) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL read_wait_quiet: bus or response activity while waiting, required none");
      end
      for (int b = 0; b < BEATS; b++) begin
         tick();
         c2_in = (b == 0) ? C2_RESPONSE : C2_NOP;
         d2_in = 16'h0100 + DATA2_W'(b);
         sample();
         checks++;
         if (rsp_valid !== 2'b01 || rsp_data !== 16'h0100 + DATA2_W'(b) ||
             rsp_last !== (b == BEATS - 1) || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL read_beat%0d: rsp_valid=%b data=%h last=%b err=%b, required 01/%h/%b/0",
                     b, rsp_valid, rsp_data, rsp_last, rsp_err, 16'h0100 + b, b == BEATS - 1);
         end
      end
      tick();
      c2_in = C2_NOP;
      d2_in = '0;
      sample();
      checks++;
      if (dbg_state !== ST_TURN || grant !== '0 || rsp_valid !== '0 || c2_oe !== 1'b0) begin
         errors++;
         $display("FAIL read_turn: state=%0d grant=%b rsp_valid=%b c2_oe=%b, required TURN/00/00/0",
                  dbg_state, grant, rsp_valid, c2_oe);
      end
      tick();
   endtask

   task automatic test_write();
      set_req(1, C2_WRITE_LINE, 32'h05);
      req_wdata[DATA2_W +: DATA2_W] = 16'h00A0;
      sample();
      checks++;
      if (grant !== 2'b10 || req_ready !== 2'b10) begin
         errors++;
         $display("FAIL write_accept: grant=%b req_ready=%b, required 10/10", grant, req_ready);
      end
      tick();
      req_valid = '0;
      sample();
      checks++;
      if (c2_oe !== 1'b1 || c2_out !== C2_WRITE_LINE || a2_out !== 32'h05 || d2_oe !== 1'b0) begin
         errors++;
         $display("FAIL write_cmd: c2_oe=%b c2_out=%0d a2_out=%h d2_oe=%b, required 1/%0d/05/0",
                  c2_oe, c2_out, a2_out, d2_oe, C2_WRITE_LINE);
      end
      for (int k = 0; k < BEATS; k++) begin
         tick();
         req_wdata[DATA2_W +: DATA2_W] = 16'h00A0 + DATA2_W'(k);
         sample();
         checks++;
         if (d2_oe !== 1'b1 || d2_out !== 16'h00A0 + DATA2_W'(k) || wdata_ready !== 2'b10 ||
             c2_oe !== 1'b1 || c2_out !== C2_WRITE_LINE) begin
            errors++;
            $display("FAIL write_beat%0d: d2_oe=%b d2_out=%h wdata_ready=%b c2_out=%0d, required 1/%h/10/%0d",
                     k, d2_oe, d2_out, wdata_ready, c2_out, 16'h00A0 + k, C2_WRITE_LINE);
         end
      end
      tick();
      sample();
      checks++;
      if (d2_oe !== 1'b0 || c2_oe !== 1'b0 || wdata_ready !== '0 || rsp_valid !== '0) begin
         errors++;
         $display("FAIL write_release: d2_oe=%b c2_oe=%b wdata_ready=%b rsp_valid=%b, required all 0",
                  d2_oe, c2_oe, wdata_ready, rsp_valid);
      end
      tick();
      tick();
      c2_in = C2_RESPONSE;
      sample();
      checks++;
      if (rsp_valid !== 2'b10 || rsp_last !== 1'b1 || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL write_rsp: rsp_valid=%b last=%b err=%b, required 10/1/0", rsp_valid, rsp_last, rsp_err);
      end
      tick();
      c2_in = C2_NOP;
      sample();
      checks++;
      if (dbg_state !== ST_TURN || rsp_valid !== '0) begin
         errors++;
         $display("FAIL write_turn: state=%0d rsp_valid=%b, required TURN/00", dbg_state, rsp_valid);
      end
      tick();
   endtask

   task automatic test_round_robin();
      logic [N_REQ-1:0] exp_gnt;
      for (int r = 0; r < 4; r++) begin
         exp_gnt = (r % 2 == 0) ? 2'b01 : 2'b10;
         set_req(0, C2_READ_LINE, 32'h40);
         set_req(1, C2_READ_LINE, 32'h41);
         sample();
         checks++;
         if (grant !== exp_gnt || req_ready !== exp_gnt) begin
            errors++;
            $display("FAIL rr_grant%0d: grant=%b req_ready=%b, required %b", r, grant, req_ready, exp_gnt);
         end
         tick();
         if (r == 3) req_valid = '0;
         tick();
         c2_in = C2_RESPONSE;
         d2_in = 16'h0400;
         for (int b = 1; b < BEATS; b++) begin
            tick();
            c2_in = C2_NOP;
            d2_in = 16'h0400 + DATA2_W'(b);
         end
         tick();
         sample();
         checks++;
         if (dbg_state !== ST_TURN || grant !== '0 || req_ready !== '0) begin
            errors++;
            $display("FAIL rr_turn%0d: state=%0d grant=%b req_ready=%b, required TURN/00/00",
                     r, dbg_state, grant, req_ready);
         end
         tick();
      end
   endtask

   task automatic test_illegal();
      set_req(0, C2_NOP, 32'h77);
      sample();
      checks++;
      if (req_ready !== 2'b01 || rsp_valid !== 2'b01 || rsp_err !== 1'b1 ||
          rsp_last !== 1'b1 || c2_oe !== 1'b0) begin
         errors++;
         $display("FAIL illegal_reject: req_ready=%b rsp_valid=%b err=%b last=%b c2_oe=%b, required 01/01/1/1/0",
                  req_ready, rsp_valid, rsp_err, rsp_last, c2_oe);
      end
      tick();
      req_valid = '0;
      sample();
      checks++;
      if (dbg_state !== ST_IDLE || c2_oe !== 1'b0 || rsp_valid !== '0) begin
         errors++;
         $display("FAIL illegal_idle: state=%0d c2_oe=%b rsp_valid=%b, required IDLE/0/00",
                  dbg_state, c2_oe, rsp_valid);
      end
      tick();
      set_req(0, C2_READ_LINE, 32'h50);
      set_req(1, C2_READ_LINE, 32'h51);
      sample();
      checks++;
      if (grant !== 2'b10) begin
         errors++;
         $display("FAIL illegal_ptr_advance: grant=%b, required 10", grant);
      end
      finish_read_quick();
   endtask

   task automatic test_timeout();
      int  waited;
      logic seen;
      set_req(0, C2_READ_LINE, 32'h30);
      sample();
      tick();
      req_valid = '0;
      sample();
      waited = 0;
      seen   = 1'b0;
      for (int k = 0; k < 400 && !seen; k++) begin
         tick();
         sample();
         if (rsp_valid !== '0) seen = 1'b1;
         else waited++;
      end
      checks++;
      if (!seen || waited != TIMEOUT || rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_last !== 1'b1) begin
         errors++;
         $display("FAIL timeout_err: seen=%b quiet_cycles=%0d rsp_valid=%b err=%b last=%b, required 1/%0d/01/1/1",
                  seen, waited, rsp_valid, rsp_err, rsp_last, TIMEOUT);
      end
      tick();
      tick();
      sample();
      checks++;
      if (dbg_state !== ST_IDLE || grant !== '0 || c2_oe !== 1'b0) begin
         errors++;
         $display("FAIL timeout_idle: state=%0d grant=%b c2_oe=%b, required IDLE/00/0", dbg_state, grant, c2_oe);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      logic bad;
      set_req(0, C2_READ_LINE, 32'h44);
      sample();
      checks++;
      if (grant !== 2'b01) begin
         errors++;
         $display("FAIL rmid_accept: grant=%b, required 01", grant);
      end
      tick();
      req_valid = '0;
      tick();
      c2_in = C2_RESPONSE;
      d2_in = 16'h0300;
      for (int b = 1; b <= 3; b++) begin
         tick();
         c2_in = C2_NOP;
         d2_in = 16'h0300 + DATA2_W'(b);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({grant, req_ready, wdata_ready, rsp_valid, rsp_data, rsp_last, rsp_err,
           a2_out, c2_out, c2_oe, d2_out, d2_oe} !== '0 || dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL rmid_outputs: rsp_valid=%b rsp_data=%h grant=%b state=%0d, required all zero and IDLE",
                  rsp_valid, rsp_data, grant, dbg_state);
      end
      @(posedge clk);
      #3 reset = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sample();
         if (rsp_valid !== '0 || dbg_state !== ST_IDLE) bad = 1'b1;
         tick();
         d2_in = 16'h0304 + DATA2_W'(i);
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL rmid_no_rsp: response or state activity after reset, required none");
      end
      set_req(0, C2_READ_LINE, 32'h60);
      set_req(1, C2_READ_LINE, 32'h61);
      sample();
      checks++;
      if (grant !== 2'b01) begin
         errors++;
         $display("FAIL rmid_ptr_reset: grant=%b, required 01", grant);
      end
      tick();
      req_valid = '0;
      sample();
      checks++;
      if (c2_oe !== 1'b1 || c2_out !== C2_READ_LINE || a2_out !== 32'h60) begin
         errors++;
         $display("FAIL rmid_resume_cmd: c2_oe=%b c2_out=%0d a2_out=%h, required 1/%0d/60",
                  c2_oe, c2_out, a2_out, C2_READ_LINE);
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_round_robin();
      test_illegal();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
